// File: rtl/add_reservation_station_pkg.sv
// Shared types for the adder reservation station: entry states, widths, tag constants.
// The ADD_RS_OLDEST_FIRST_EN macro (see the top level) switches dispatch to oldest-first.
package add_reservation_station_pkg;

  localparam int DATA_W = 8;
  localparam int TAG_W  = 3;
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef enum logic [1:0] {
    RS_FREE  = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2,
    RS_EXEC  = 2'd3
  } rs_state_e;

  typedef struct packed {
    rs_state_e         state;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
  } rs_entry_t;

  // A waiting operand is satisfied by a valid broadcast of its producer tag; tag 0 never matches.
  function automatic logic cdb_hit(input logic [TAG_W-1:0] q, input logic valid,
                                   input logic [TAG_W-1:0] tag);
    return valid && (tag != NO_TAG) && (q == tag);
  endfunction

endpackage

// File: rtl/add_reservation_station_rs_entry.sv
// One reservation-station entry: FREE/WAIT/READY/EXEC state machine with CDB operand capture
// and issue-cycle bypass.
module add_reservation_station_rs_entry
  import add_reservation_station_pkg::*;
#(
  parameter logic [TAG_W-1:0] MY_TAG = 3'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              dispatch,
  output rs_state_e         state,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);

  rs_entry_t entry_reg, entry_next;

  always_comb begin
    entry_next = entry_reg;
    case (entry_reg.state)
      RS_FREE: begin
        if (alloc) begin
          entry_next.qj = cdb_hit(issue_qj, cdb_valid, cdb_tag) ? NO_TAG : issue_qj;
          entry_next.vj = cdb_hit(issue_qj, cdb_valid, cdb_tag) ? cdb_data : issue_vj;
          entry_next.qk = cdb_hit(issue_qk, cdb_valid, cdb_tag) ? NO_TAG : issue_qk;
          entry_next.vk = cdb_hit(issue_qk, cdb_valid, cdb_tag) ? cdb_data : issue_vk;
          entry_next.state = (entry_next.qj == NO_TAG && entry_next.qk == NO_TAG) ?
                             RS_READY : RS_WAIT;
        end
      end
      RS_WAIT: begin
        if (cdb_hit(entry_reg.qj, cdb_valid, cdb_tag)) begin
          entry_next.qj = NO_TAG;
          entry_next.vj = cdb_data;
        end
        if (cdb_hit(entry_reg.qk, cdb_valid, cdb_tag)) begin
          entry_next.qk = NO_TAG;
          entry_next.vk = cdb_data;
        end
        // Becomes visible to the dispatch selector only from the following cycle.
        if (entry_next.qj == NO_TAG && entry_next.qk == NO_TAG)
          entry_next.state = RS_READY;
      end
      RS_READY: begin
        if (dispatch)
          entry_next.state = RS_EXEC;
      end
      RS_EXEC: begin
        if (cdb_valid && cdb_tag != NO_TAG && cdb_tag == MY_TAG)
          entry_next.state = RS_FREE;
      end
      default: entry_next.state = RS_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      entry_reg <= '0;
    else
      entry_reg <= entry_next;
  end

  assign state = entry_reg.state;
  assign vj    = entry_reg.vj;
  assign vk    = entry_reg.vk;

endmodule

// File: rtl/add_reservation_station.sv
// Adder reservation station: free-slot allocator, dispatch selector and registered adder interface.
// Define ADD_RS_OLDEST_FIRST_EN to dispatch the oldest READY entry instead of the lowest index.
module add_reservation_station
  import add_reservation_station_pkg::*;
#(
  parameter int NUM_RS   = 3,
  parameter int TAG_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vk,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              ADD_Status,
  output logic [DATA_W-1:0] ADD_Operand1,
  output logic [DATA_W-1:0] ADD_Operand2,
  output logic [TAG_W-1:0]  ADD_Tag_ip,
  output logic              dispatch_valid,
  output logic [NUM_RS-1:0] rs_busy
);

  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  rs_state_e         entry_state [NUM_RS];
  logic [DATA_W-1:0] entry_vj    [NUM_RS];
  logic [DATA_W-1:0] entry_vk    [NUM_RS];
  logic [NUM_RS-1:0] free_vec, ready_vec, alloc_vec, dispatch_vec;
  logic [IDX_W-1:0]  alloc_idx, sel_idx;
  logic              alloc_found, sel_found, issue_fire, dispatch_go;

  logic              block_reg;
  logic              dispatch_valid_reg;
  logic [DATA_W-1:0] operand1_reg, operand2_reg;
  logic [TAG_W-1:0]  tag_ip_reg;

  generate
    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_entry
      assign free_vec[gi]     = (entry_state[gi] == RS_FREE);
      assign ready_vec[gi]    = (entry_state[gi] == RS_READY);
      assign alloc_vec[gi]    = issue_fire && (alloc_idx == IDX_W'(gi));
      assign dispatch_vec[gi] = dispatch_go && (sel_idx == IDX_W'(gi));

      add_reservation_station_rs_entry #(
        .MY_TAG(TAG_W'(TAG_BASE + gi))
      ) u_entry (
        .clk      (clk),
        .rst      (rst),
        .alloc    (alloc_vec[gi]),
        .issue_qj (issue_qj),
        .issue_vj (issue_vj),
        .issue_qk (issue_qk),
        .issue_vk (issue_vk),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .dispatch (dispatch_vec[gi]),
        .state    (entry_state[gi]),
        .vj       (entry_vj[gi]),
        .vk       (entry_vk[gi])
      );
    end
  endgenerate

  // Descending scan so the lowest free index wins.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_ready = alloc_found;
  assign issue_fire  = issue_valid && alloc_found;
  assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(alloc_idx);

`ifdef ADD_RS_OLDEST_FIRST_EN
  logic [1:0] age_reg [NUM_RS];
  logic [1:0] best_age;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RS; i++) begin
      if (rst)
        age_reg[i] <= '0;
      else if (issue_fire) begin
        if (alloc_vec[i])
          age_reg[i] <= '0;
        else if (age_reg[i] != 2'd3)
          age_reg[i] <= age_reg[i] + 2'd1;
      end
    end
  end

  // Strict comparison keeps the lowest index on equal ages.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (ready_vec[i] && (!sel_found || age_reg[i] > best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_reg[i];
      end
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // block_reg holds off dispatch until the adder has gone busy (status 0) after the last one.
  assign dispatch_go = ADD_Status && !block_reg && sel_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      block_reg          <= 1'b0;
      dispatch_valid_reg <= 1'b0;
      operand1_reg       <= '0;
      operand2_reg       <= '0;
      tag_ip_reg         <= '0;
    end else begin
      dispatch_valid_reg <= dispatch_go;
      if (dispatch_go) begin
        operand1_reg <= entry_vj[sel_idx];
        operand2_reg <= entry_vk[sel_idx];
        tag_ip_reg   <= TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
        block_reg    <= 1'b1;
      end else if (!ADD_Status) begin
        block_reg <= 1'b0;
      end
    end
  end

  assign dispatch_valid = dispatch_valid_reg;
  assign ADD_Operand1   = operand1_reg;
  assign ADD_Operand2   = operand2_reg;
  assign ADD_Tag_ip     = tag_ip_reg;
  assign rs_busy        = ~free_vec;

endmodule

// File: tb/tb_add_reservation_station.sv
// Bench for add_reservation_station: directed vector table, then random traffic against a reference model.
module tb_add_reservation_station;

  localparam int NUM_RS   = 3;
  localparam int TAG_BASE = 1;
  localparam int NV       = 32;
  localparam int N_RAND   = 1500;
  localparam int S_FREE = 0, S_WAIT = 1, S_READY = 2, S_EXEC = 3;

  logic       clk = 1'b0;
  logic       rst, issue_valid, cdb_valid, add_status;
  logic [2:0] issue_qj, issue_qk, cdb_tag;
  logic [7:0] issue_vj, issue_vk, cdb_data;
  logic       issue_ready, dispatch_valid;
  logic [2:0] issue_tag, add_tag_ip, rs_busy;
  logic [7:0] add_op1, add_op2;

  always #5 clk = ~clk;

  add_reservation_station #(.NUM_RS(NUM_RS), .TAG_BASE(TAG_BASE)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_qj(issue_qj), .issue_vj(issue_vj), .issue_qk(issue_qk), .issue_vk(issue_vk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ADD_Status(add_status), .ADD_Operand1(add_op1), .ADD_Operand2(add_op2),
    .ADD_Tag_ip(add_tag_ip), .dispatch_valid(dispatch_valid), .rs_busy(rs_busy)
  );

  // Inputs for one cycle plus the outputs expected in that cycle (before its edge).
  typedef struct {
    int rst, iv, qj, vj, qk, vk, cv, ct, cd, st;
    int e_dv, e_op1, e_op2, e_tip, e_busy, e_rdy, e_tag;
  } vec_t;

  vec_t vecs [NV];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: entries as plain arrays, updated from the behavioural rules once per edge.
  int m_state [NUM_RS];
  int m_qj [NUM_RS], m_qk [NUM_RS], m_vj [NUM_RS], m_vk [NUM_RS], m_age [NUM_RS];
  int m_block, m_dv, m_op1, m_op2, m_tip;

  function automatic vec_t mk(int rst_i, int iv, int qj, int vj, int qk, int vk,
                              int cv, int ct, int cd, int st, int e_dv, int e_op1,
                              int e_op2, int e_tip, int e_busy, int e_rdy, int e_tag);
    vec_t v;
    v.rst = rst_i; v.iv = iv; v.qj = qj; v.vj = vj; v.qk = qk; v.vk = vk;
    v.cv = cv; v.ct = ct; v.cd = cd; v.st = st;
    v.e_dv = e_dv; v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_tip = e_tip;
    v.e_busy = e_busy; v.e_rdy = e_rdy; v.e_tag = e_tag;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_RS; i++) begin
      m_state[i] = S_FREE; m_qj[i] = 0; m_qk[i] = 0; m_vj[i] = 0; m_vk[i] = 0; m_age[i] = 0;
    end
    m_block = 0; m_dv = 0; m_op1 = 0; m_op2 = 0; m_tip = 0;
  endtask

  function automatic int model_pick();
    int best = -1;
    for (int i = 0; i < NUM_RS; i++) begin
      if (m_state[i] == S_READY) begin
`ifdef ADD_RS_OLDEST_FIRST_EN
        if (best < 0 || m_age[i] > m_age[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  task automatic model_edge(input vec_t v);
    int f, d;
    if (v.rst != 0) begin
      model_reset();
      return;
    end
    d = (v.st != 0 && m_block == 0) ? model_pick() : -1;
    f = -1;
    for (int i = NUM_RS - 1; i >= 0; i--) if (m_state[i] == S_FREE) f = i;
    for (int i = 0; i < NUM_RS; i++) begin
      if (m_state[i] == S_EXEC && v.cv != 0 && v.ct == TAG_BASE + i) m_state[i] = S_FREE;
      else if (m_state[i] == S_WAIT) begin
        if (v.cv != 0 && v.ct != 0 && m_qj[i] == v.ct) begin m_qj[i] = 0; m_vj[i] = v.cd; end
        if (v.cv != 0 && v.ct != 0 && m_qk[i] == v.ct) begin m_qk[i] = 0; m_vk[i] = v.cd; end
        if (m_qj[i] == 0 && m_qk[i] == 0) m_state[i] = S_READY;
      end
    end
    m_dv = (d >= 0) ? 1 : 0;
    if (d >= 0) begin
      m_op1 = m_vj[d]; m_op2 = m_vk[d]; m_tip = TAG_BASE + d;
      m_state[d] = S_EXEC; m_block = 1;
    end else if (v.st == 0) m_block = 0;
    if (v.iv != 0 && f >= 0) begin
      for (int i = 0; i < NUM_RS; i++) if (i != f && m_age[i] < 3) m_age[i]++;
      m_age[f] = 0;
      m_qj[f] = v.qj; m_vj[f] = v.vj; m_qk[f] = v.qk; m_vk[f] = v.vk;
      if (v.cv != 0 && v.ct != 0 && v.qj == v.ct) begin m_qj[f] = 0; m_vj[f] = v.cd; end
      if (v.cv != 0 && v.ct != 0 && v.qk == v.ct) begin m_qk[f] = 0; m_vk[f] = v.cd; end
      m_state[f] = (m_qj[f] == 0 && m_qk[f] == 0) ? S_READY : S_WAIT;
    end
  endtask

  // Fills the expected-output fields from the model's current state.
  function automatic vec_t model_expect(input vec_t v);
    vec_t r = v;
    r.e_dv = m_dv; r.e_op1 = m_op1; r.e_op2 = m_op2; r.e_tip = m_tip;
    r.e_busy = 0; r.e_rdy = 0; r.e_tag = 0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (m_state[i] != S_FREE) r.e_busy = r.e_busy | (1 << i);
      else begin r.e_rdy = 1; r.e_tag = TAG_BASE + i; end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic run_cycle(input vec_t v, input int use_model, input int idx);
    vec_t e;
    rst = 1'(v.rst); issue_valid = 1'(v.iv);
    issue_qj = 3'(v.qj); issue_vj = 8'(v.vj); issue_qk = 3'(v.qk); issue_vk = 8'(v.vk);
    cdb_valid = 1'(v.cv); cdb_tag = 3'(v.ct); cdb_data = 8'(v.cd); add_status = 1'(v.st);
    #1;
    e = (use_model != 0) ? model_expect(v) : v;
    chk("dispatch_valid", int'(dispatch_valid), e.e_dv);
    chk("ADD_Operand1", int'(add_op1), e.e_op1);
    chk("ADD_Operand2", int'(add_op2), e.e_op2);
    chk("ADD_Tag_ip", int'(add_tag_ip), e.e_tip);
    chk("rs_busy", int'(rs_busy), e.e_busy);
    chk("issue_ready", int'(issue_ready), e.e_rdy);
    if (e.e_rdy != 0) chk("issue_tag", int'(issue_tag), e.e_tag);
    if (use_model == 0)
      $display("vec %0d: rst=%0d issue=%0d cdb=%0d/%0d st=%0d -> dv=%0d busy=%0b rdy=%0d",
               idx, v.rst, v.iv, v.cv, v.ct, v.st, dispatch_valid, rs_busy, issue_ready);
    else if (dispatch_valid)
      $display("rand %0d: dispatch tag=%0d op1=0x%0h op2=0x%0h", idx, add_tag_ip, add_op1, add_op2);
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
  endtask

  initial begin
    vec_t r;
    rst = 1'b1; issue_valid = 0; issue_qj = 0; issue_vj = 0; issue_qk = 0; issue_vk = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; add_status = 0;

    //                rst iv qj vj   qk vk cv ct cd    st | dv op1   op2 tip busy rdy tag
    // simple issue -> dispatch -> completion
    vecs[0]  = mk(0, 1, 0, 5,    0, 7, 0, 0, 0,    1,   0, 0,    0, 0, 0, 1, 1);
    vecs[1]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1,   0, 0,    0, 0, 1, 1, 2);
    vecs[2]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   1, 5,    7, 1, 1, 1, 2);
    vecs[3]  = mk(0, 0, 0, 0,    0, 0, 1, 1, 12,   1,   0, 5,    7, 1, 1, 1, 2);
    // operand waits for tag 2, then dispatches the cycle after capture
    vecs[4]  = mk(0, 1, 2, 0,    0, 3, 0, 0, 0,    1,   0, 5,    7, 1, 0, 1, 1);
    vecs[5]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1,   0, 5,    7, 1, 1, 1, 2);
    vecs[6]  = mk(0, 0, 0, 0,    0, 0, 1, 2, 9,    1,   0, 5,    7, 1, 1, 1, 2);
    vecs[7]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1,   0, 5,    7, 1, 1, 1, 2);
    vecs[8]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   1, 9,    3, 1, 1, 1, 2);
    vecs[9]  = mk(0, 0, 0, 0,    0, 0, 1, 1, 0,    1,   0, 9,    3, 1, 1, 1, 2);
    // issue-cycle bypass of tag 4
    vecs[10] = mk(0, 1, 4, 0,    0, 2, 1, 4, 8'h11, 1,  0, 9,    3, 1, 0, 1, 1);
    vecs[11] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1,   0, 9,    3, 1, 1, 1, 2);
    vecs[12] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   1, 8'h11, 2, 1, 1, 1, 2);
    vecs[13] = mk(0, 0, 0, 0,    0, 0, 1, 1, 0,    1,   0, 8'h11, 2, 1, 1, 1, 2);
    // fill all entries while the adder is busy; fourth issue is refused
    vecs[14] = mk(0, 1, 0, 1,    0, 2, 0, 0, 0,    0,   0, 8'h11, 2, 1, 0, 1, 1);
    vecs[15] = mk(0, 1, 0, 3,    0, 4, 0, 0, 0,    0,   0, 8'h11, 2, 1, 1, 1, 2);
    vecs[16] = mk(0, 1, 0, 5,    0, 6, 0, 0, 0,    0,   0, 8'h11, 2, 1, 3, 1, 3);
    vecs[17] = mk(0, 1, 0, 7,    0, 8, 0, 0, 0,    0,   0, 8'h11, 2, 1, 7, 0, 0);
    // drain: one dispatch per status 0->1 window
    vecs[18] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1,   0, 8'h11, 2, 1, 7, 0, 0);
    vecs[19] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1,   1, 1,    2, 1, 7, 0, 0);
    vecs[20] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   0, 1,    2, 1, 7, 0, 0);
    vecs[21] = mk(0, 0, 0, 0,    0, 0, 1, 1, 0,    1,   0, 1,    2, 1, 7, 0, 0);
    vecs[22] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   1, 3,    4, 2, 6, 1, 1);
    vecs[23] = mk(0, 0, 0, 0,    0, 0, 1, 2, 0,    1,   0, 3,    4, 2, 6, 1, 1);
    vecs[24] = mk(0, 0, 0, 0,    0, 0, 1, 3, 0,    0,   1, 5,    6, 3, 4, 1, 1);
    // reset with one entry in EXEC and one in WAIT, then stale CDB tags
    vecs[25] = mk(0, 1, 0, 1,    0, 1, 0, 0, 0,    1,   0, 5,    6, 3, 0, 1, 1);
    vecs[26] = mk(0, 1, 5, 0,    0, 0, 0, 0, 0,    1,   0, 5,    6, 3, 1, 1, 2);
    vecs[27] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   1, 1,    1, 1, 3, 1, 3);
    vecs[28] = mk(1, 0, 0, 0,    0, 0, 0, 0, 0,    1,   0, 1,    1, 1, 3, 1, 3);
    vecs[29] = mk(0, 0, 0, 0,    0, 0, 1, 1, 8'h55, 1,  0, 0,    0, 0, 0, 1, 1);
    vecs[30] = mk(0, 0, 0, 0,    0, 0, 1, 5, 0,    1,   0, 0,    0, 0, 0, 1, 1);
    vecs[31] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1,   0, 0,    0, 0, 0, 1, 1);

    @(negedge clk);
    @(negedge clk);
    model_reset();

    for (int k = 0; k < NV; k++) run_cycle(vecs[k], 0, k);

    for (int n = 0; n < N_RAND; n++) begin
      r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      r.rst = ($urandom_range(0, 299) == 0) ? 1 : 0;
      r.iv  = int'($urandom_range(0, 1));
      r.qj  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
      r.vj  = int'($urandom_range(0, 255));
      r.qk  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
      r.vk  = int'($urandom_range(0, 255));
      r.cv  = ($urandom_range(0, 2) != 0) ? 1 : 0;
      r.ct  = int'($urandom_range(0, 5));
      r.cd  = int'($urandom_range(0, 255));
      r.st  = ($urandom_range(0, 2) != 0) ? 1 : 0;
      run_cycle(r, 1, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/add_reservation_station.md
Name: add_reservation_station

Overview:
- Issue-side partner of the adder functional unit in the Tomasulo core.
- Holds NUM_RS pending ADD operations, each with its own tag.
- Captures missing operands from the common data bus (CDB) by tag match.
- Dispatches one ready entry to the adder when ADD_Status reports it free, and releases the entry when the adder's result with that tag appears on the CDB.

Parameters:
- NUM_RS, 3, number of entries; entry i owns tag TAG_BASE+i.
- DATA_W, 8, operand/result width.
- TAG_W, 3, tag width; tag 0 means "value present, no producer".
- TAG_BASE, 1, tag of entry 0; TAG_BASE+NUM_RS-1 must be < 2^TAG_W.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- issue_valid  input  1  decoder presents an ADD this cycle.
- issue_ready  output  1  at least one entry is FREE.
- issue_qj  input  TAG_W  producer tag of operand 1; 0 means issue_vj is valid.
- issue_vj  input  DATA_W  operand 1 value.
- issue_qk  input  TAG_W  producer tag of operand 2; 0 means issue_vk is valid.
- issue_vk  input  DATA_W  operand 2 value.
- issue_tag  output  TAG_W  tag the next issue will receive; the decoder writes it to the register status table.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  TAG_W  broadcasting tag.
- cdb_data  input  DATA_W  broadcast value.
- ADD_Status  input  1  1 means the adder is free to accept an operation.
- ADD_Operand1  output  DATA_W  dispatched operand 1.
- ADD_Operand2  output  DATA_W  dispatched operand 2.
- ADD_Tag_ip  output  TAG_W  tag of the dispatched entry.
- dispatch_valid  output  1  one-cycle strobe qualifying ADD_Operand1, ADD_Operand2 and ADD_Tag_ip.
- rs_busy  output  NUM_RS  per-entry non-FREE flags, for debug and the stall logic.

Behaviour:
- Per-entry state: FREE, WAIT (one or more qj/qk nonzero), READY (qj=qk=0), EXEC (dispatched, result pending).
- Reset:
  - All entries FREE; all qj/qk/vj/vk cleared.
  - Outputs: dispatch_valid=0, ADD_Operand1=0, ADD_Operand2=0, ADD_Tag_ip=0, rs_busy=0, issue_ready=1, issue_tag=TAG_BASE.
  - Reset mid-operation discards every entry, including EXEC entries; a later CDB result carrying their tag is ignored.
- Issue:
  - Fires on issue_valid & issue_ready. It allocates the lowest-index FREE entry; issue_tag shows that entry's tag combinationally.
  - The new entry goes to READY if both q are 0, else WAIT.
  - If issue_valid and not issue_ready, the request is ignored; the decoder must hold it.
- Issue/CDB bypass: if cdb_valid and cdb_tag equals a nonzero issue_qj (or issue_qk) in the issue cycle, the entry latches cdb_data and stores q=0.
- Capture: each cycle, every WAIT entry with qj==cdb_tag (nonzero, cdb_valid) latches vj=cdb_data and qj=0; the same applies to qk. An entry moves WAIT->READY on the cycle after both q reach 0.
- Dispatch (registered):
  - When ADD_Status=1 and no dispatch is outstanding, select one READY entry (lowest index by default) and do all of the following at the next edge:
    - drive ADD_Operand1=vj, ADD_Operand2=vk, ADD_Tag_ip=entry tag;
    - pulse dispatch_valid for 1 cycle;
    - move the entry to EXEC.
  - At most one dispatch per cycle.
  - After a dispatch, block further dispatch until ADD_Status has been observed 0 then 1 again. This covers the adder's multi-cycle busy window.
  - Operand outputs hold their last values when dispatch_valid=0.
- Completion:
  - cdb_valid with cdb_tag equal to an EXEC entry's tag returns that entry to FREE in the same edge.
  - That entry can be reallocated by an issue on the following cycle, not the same cycle.
- Simultaneous events:
  - Capture and dispatch in one cycle: the capture makes the entry eligible only from the next cycle.
  - Completion and issue in one cycle: the issue uses another FREE entry if one exists; otherwise issue_ready=0 that cycle.
- A CDB tag matching no entry is ignored. Tag 0 on the CDB is never matched.
- Full: issue_ready=0 when all NUM_RS entries are non-FREE. Empty: dispatch_valid stays 0.

Optional Feature:
- Macro: ADD_RS_OLDEST_FIRST_EN.
- Defined: each entry carries a 2-bit age counter, reset to 0 on issue and incremented (saturating) on every later issue. Dispatch selects the READY entry with the largest age; ties go to the lowest index.
- Undefined: no age state; dispatch is fixed lowest-index priority.

Decomposition:
- Shared package: entry-state encoding (FREE/WAIT/READY/EXEC), TAG_W, DATA_W, the NO_TAG=0 constant, and the entry record typedef (state, qj, qk, vj, vk).
- Sub-module rs_entry: one entry's state machine plus capture logic, instantiated NUM_RS times.
- Top level: free-slot allocator, dispatch selector and output registers.

Test Plan:
- Reset then issue qj=0,vj=5,qk=0,vk=7 with ADD_Status=1 -> issue_tag=1; dispatch_valid pulses two edges after issue with ADD_Operand1=5, ADD_Operand2=7, ADD_Tag_ip=1; CDB tag 1 frees the entry, so rs_busy=000.
- Issue qj=2 (vk=3 ready), later CDB tag 2 data 9 -> entry waits, then dispatches 9,3 the cycle after capture.
- Issue with qj=4 while CDB tag 4 data 0x11 is valid in the same cycle -> vj=0x11 latched via bypass; no extra wait.
- Fill 3 entries with ADD_Status=0 -> issue_ready=0 and a fourth issue is ignored; after ADD_Status=1 and completions, entries drain in priority order, one dispatch per ADD_Status 0->1 window.
- Assert rst with one entry EXEC and one WAIT -> all outputs return to reset values; a later CDB with the old tag produces no dispatch and no state change.
- With ADD_RS_OLDEST_FIRST_EN, issue entries 0,1,2 with entry 0 waiting and entries 1,2 ready -> entry 1 dispatches first; without the macro, entry 1 also dispatches first. After entry 0 becomes ready, the macro build dispatches 0 before 2 and the default build dispatches 0 (lowest index) before 2.
